// File: rtl/text_core_v2.sv
// text_core_v2: multicycle fetch/decode/execute accumulator core that drives a
// single-port synchronous RAM holding both program and display text.
//
// Ports:
//   clk          system clock; all state changes on the rising edge
//   rst          asynchronous, active-high reset
//   run          1 = execute; only looked at while fetching
//   readData     RAM read data, valid one cycle after the address is presented
//   writeData    RAM write data (acc during STORE, otherwise 0)
//   writeEnable  RAM write strobe, one cycle per STORE
//   address      RAM address
//   pc_out       current program counter (debug)
//   paused       high while the PAUSE state is active
//
// Handshake: there is no valid/ready pair. The RAM is a fixed-latency slave:
// an address presented in cycle N is answered on readData in cycle N+1, and a
// write strobe in cycle N updates the RAM at the end of cycle N.
module text_core_v2 #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned START_ADDR   = 16'h2400,
    parameter int unsigned END_ADDR     = 16'h27FF,
    parameter int unsigned BASE_ADDR    = 16'h0000,
    parameter int unsigned PAUSE_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [DATA_W-1:0] readData,
    output logic [DATA_W-1:0] writeData,
    output logic              writeEnable,
    output logic [ADDR_W-1:0] address,
    output logic [ADDR_W-1:0] pc_out,
    output logic              paused
);
    localparam int unsigned IMM_W = DATA_W - 4;
    localparam int unsigned CNT_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;

    localparam logic [ADDR_W-1:0] START_PC  = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] END_PC    = ADDR_W'(END_ADDR);
    localparam logic [ADDR_W-1:0] BASE_PTR  = ADDR_W'(BASE_ADDR);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PAUSE_CYCLES - 1);

    localparam logic [3:0] OP_RESTART = 4'd0;
    localparam logic [3:0] OP_LOAD    = 4'd1;
    localparam logic [3:0] OP_STORE   = 4'd2;
    localparam logic [3:0] OP_ADVANCE = 4'd3;
    localparam logic [3:0] OP_INC     = 4'd4;
    localparam logic [3:0] OP_PAUSE   = 4'd5;
    localparam logic [3:0] OP_ADD     = 4'd6;
    localparam logic [3:0] OP_MOVE    = 4'd7;
    localparam logic [3:0] OP_LDI     = 4'd8;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_PAUSE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mptr_q, mptr_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [3:0]        opcode;
    logic [IMM_W-1:0]  imm;

    assign opcode = ir_q[DATA_W-1 -: 4];
    assign imm    = ir_q[IMM_W-1:0];
    assign pc_out = pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= START_PC;
            mptr_q  <= '0;
            acc_q   <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mptr_q  <= mptr_d;
            acc_q   <= acc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        mptr_d      = mptr_q;
        acc_d       = acc_q;
        ir_d        = ir_q;
        cnt_d       = cnt_q;
        address     = '0;
        writeData   = '0;
        writeEnable = 1'b0;
        paused      = 1'b0;

        case (state_q)
            ST_FETCH: begin
                address = pc_q;
                if (run) begin
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                // Instruction word arrives now; point the RAM at mptr so the
                // operand is on readData during EXEC.
                address = mptr_q;
                ir_d    = readData;
                pc_d    = (pc_q == END_PC) ? START_PC : pc_q + ADDR_W'(1);
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                address = mptr_q;
                state_d = ST_FETCH;
                case (opcode)
                    OP_RESTART: pc_d = START_PC;   // overrides the DECODE increment
                    OP_LOAD:    acc_d = readData;
                    OP_STORE: begin
                        writeData   = acc_q;
                        writeEnable = 1'b1;
                    end
                    OP_ADVANCE: mptr_d = mptr_q + ADDR_W'(1);
                    OP_INC:     acc_d = acc_q + DATA_W'(1);
                    OP_PAUSE: begin
                        state_d = ST_PAUSE;
                        cnt_d   = '0;
                    end
                    OP_ADD:     acc_d = acc_q + readData;
                    OP_MOVE:    mptr_d = BASE_PTR + ADDR_W'(imm);
                    OP_LDI:     acc_d = DATA_W'(imm);
                    default:    ;
                endcase
            end

            ST_PAUSE: begin
                paused = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = ST_FETCH;
        endcase
    end
endmodule
